axi_lite_to_apb_bridge: RTL

Downstream AXI4-Lite slave that consumes the AXI4-Lite master port of the full-AXI-to-Lite conversion stage and drives a single APB4 (AMBA 3/4 compatible) master port. It runs one transaction at a time through a SETUP/ACCESS state machine and arbitrates between reads and writes. It registers the B and R responses and maps PSLVERR and an optional PREADY timeout to AXI response codes.

---
 rtl/axi_lite_to_apb_bridge_pkg.sv | 60 ++++++
 rtl/axi_lite_to_apb_bridge_if.sv | 19 +
 rtl/axi_lite_to_apb_bridge.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/axi_lite_to_apb_bridge_pkg.sv
// Shared types for the AXI4-Lite to APB4 bridge:
// FSM states, response codes and the AXI4-Lite channel structs.
package axi_lite_apb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [2:0]        prot;
  } ax_chan_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
  } w_chan_t;

  typedef struct packed {
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } lite_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    w_ready;
    b_chan_t b;
    logic    b_valid;
    logic    ar_ready;
    r_chan_t r;
    logic    r_valid;
  } lite_resp_t;

endpackage

// File: rtl/axi_lite_to_apb_bridge_if.sv
// AXI4-Lite request/response bundle between the
// upstream Lite master and the APB bridge.
interface axi_lite_to_apb_bridge_if;
  import axi_lite_apb_pkg::*;

  lite_req_t  req;
  lite_resp_t resp;

  modport master (
    output req,
    input  resp
  );

  modport slave (
    input  req,
    output resp
  );

endinterface

// File: rtl/axi_lite_to_apb_bridge.sv
// AXI4-Lite slave to APB4 master, one transfer at a time,
// with read/write arbitration and optional PREADY timeout.
module axi_lite_to_apb_bridge
  import axi_lite_apb_pkg::*;
#(
  parameter int unsigned AddrWidth     = ADDR_W,
  parameter int unsigned DataWidth     = DATA_W,
  parameter int unsigned TimeoutCycles = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  axi_lite_to_apb_bridge_if.slave slv,
  output logic [AddrWidth-1:0]   paddr_o,
  output logic [2:0]             pprot_o,
  output logic                   psel_o,
  output logic                   penable_o,
  output logic                   pwrite_o,
  output logic [DataWidth-1:0]   pwdata_o,
  output logic [DataWidth/8-1:0] pstrb_o,
  input  logic [DataWidth-1:0]   prdata_i,
  input  logic                   pready_i,
  input  logic                   pslverr_i
);

  localparam int unsigned StrbWidth = DataWidth / 8;

  state_e r_state;
  state_e w_next;

  logic [AddrWidth-1:0] r_addr;
  logic [2:0]           r_prot;
  logic [DataWidth-1:0] r_wdata;
  logic [DataWidth-1:0] r_rdata;
  logic [StrbWidth-1:0] r_strb;
  logic [1:0]           r_resp;
  logic                 r_write;
  logic                 r_prefer_write;

  logic w_idle;
  logic w_rd_pend;
  logic w_wr_pend;
  logic w_both;
  logic w_pick_wr;
  logic w_accept;
  logic w_done;
  logic w_timeout;
  logic w_resp_hs;

  // Readies stay low while reset is asserted.
  assign w_idle    = (r_state == IDLE) & ~rst_i;
  assign w_rd_pend = slv.req.ar_valid;
  assign w_wr_pend = slv.req.aw_valid
                   & slv.req.w_valid;
  assign w_both    = w_rd_pend & w_wr_pend;
  assign w_pick_wr = w_wr_pend
                   & (~w_rd_pend | r_prefer_write);
  assign w_accept  = w_idle
                   & (w_rd_pend | w_wr_pend);
  assign w_done    = (r_state == ACCESS)
                   & (pready_i | w_timeout);
  assign w_resp_hs = (r_state == RESP)
                   & (r_write ? slv.req.b_ready
                              : slv.req.r_ready);

  if (TimeoutCycles != 0) begin : g_timeout
    localparam int unsigned CntW =
      $clog2(TimeoutCycles + 1);
    logic [CntW-1:0] r_cnt;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_cnt <= '0;
      end else if ((r_state == ACCESS)
                   & ~pready_i & ~w_timeout) begin
        r_cnt <= r_cnt + CntW'(1);
      end else begin
        r_cnt <= '0;
      end
    end

    assign w_timeout = (r_state == ACCESS)
                     & ~pready_i
                     & (r_cnt == CntW'(TimeoutCycles - 1));
  end else begin : g_no_timeout
    assign w_timeout = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next = SETUP;
      SETUP:   w_next = ACCESS;
      ACCESS:  if (w_done) w_next = RESP;
      RESP:    if (w_resp_hs) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    slv.resp          = '0;
    slv.resp.ar_ready = w_accept & ~w_pick_wr;
    slv.resp.aw_ready = w_accept & w_pick_wr;
    slv.resp.w_ready  = w_accept & w_pick_wr;
    slv.resp.b_valid  = (r_state == RESP) & r_write;
    slv.resp.r_valid  = (r_state == RESP) & ~r_write;
    slv.resp.b.resp   = r_resp;
    slv.resp.r.resp   = r_resp;
    slv.resp.r.data   = DATA_W'(r_rdata);
    psel_o            = (r_state == SETUP)
                      | (r_state == ACCESS);
    penable_o         = (r_state == ACCESS);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_addr         <= '0;
      r_prot         <= '0;
      r_wdata        <= '0;
      r_rdata        <= '0;
      r_strb         <= '0;
      r_resp         <= RESP_OKAY;
      r_write        <= 1'b0;
      r_prefer_write <= 1'b0;
    end else begin
      if (w_accept) begin
        r_write <= w_pick_wr;
        if (w_both) begin
          r_prefer_write <= ~r_prefer_write;
        end
        if (w_pick_wr) begin
          r_addr  <= AddrWidth'(slv.req.aw.addr);
          r_prot  <= slv.req.aw.prot;
          r_wdata <= DataWidth'(slv.req.w.data);
          r_strb  <= StrbWidth'(slv.req.w.strb);
        end else begin
          r_addr  <= AddrWidth'(slv.req.ar.addr);
          r_prot  <= slv.req.ar.prot;
          r_wdata <= '0;
          r_strb  <= '0;
        end
      end
      if (w_done) begin
        if (pready_i) begin
          r_resp  <= pslverr_i ? RESP_SLVERR
                               : RESP_OKAY;
          r_rdata <= r_write ? '0 : prdata_i;
        end else begin
          r_resp  <= RESP_DECERR;
          r_rdata <= '0;
        end
      end
    end
  end

  assign paddr_o  = r_addr;
  assign pprot_o  = r_prot;
  assign pwrite_o = r_write;
  assign pwdata_o = r_wdata;
  assign pstrb_o  = r_strb;

endmodule
